// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader_if
// Purpose  : Bundles the FIFO read port (rd_en/rd_data/empty) and the
//            outgoing ready/valid stream (m_valid/m_data/m_ready) used by
//            fifo_stream_reader. master = the reader, slave = FIFO + consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  // FIFO read port
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  // Output stream
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output rd_en,
    input  rd_data,
    input  empty,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output empty,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains an AsyncFIFO read port (rd_clk side) into a ready/valid
//            stream. A credit-controlled circular buffer absorbs the FIFO's
//            one-cycle read latency so the consumer may stall freely.
//            Optional feature macro: FIFO_READER_STATS_EN (delivered-word
//            counter on word_count; tied to zero when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4   // power of two, 2..8
) (
  input  wire logic                       clk,
  input  wire logic                       rstn,
  input  wire logic                       flush,
  fifo_stream_reader_if.master            bus,
  output logic [$clog2(BUF_DEPTH):0]      buf_level,
  output logic [31:0]                     word_count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      cnt;
  logic                  inflight;

  logic [CNT_W-1:0]      credit_used;
  logic                  capture;
  logic                  pop;

  // Words already owned by the reader: buffered plus the one on its way.
  // Issue only while that total leaves room, so a capture can never land
  // in a full buffer regardless of what the consumer does.
  assign credit_used = cnt + {{PTR_W{1'b0}}, inflight};
  assign bus.rd_en   = rstn && !flush && !bus.empty &&
                       (credit_used < CNT_W'(BUF_DEPTH));

  assign capture     = inflight;
  assign pop         = bus.m_valid && bus.m_ready;

  assign bus.m_valid = (cnt != '0);
  assign bus.m_data  = buf_mem[head];
  assign buf_level   = cnt;

  // Buffer, pointers, occupancy and in-flight tracking. Flush drops the
  // buffered words and the word currently arriving on rd_data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= bus.rd_en;
      if (capture) begin
        buf_mem[tail] <= bus.rd_data;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({capture, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Delivered-word counter: survives flush, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 32'd1;
    end
  end
`else
  assign word_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader. The FIFO read port
//            is a queue with registered read data; expected stream contents
//            come from a queue of words taken out of the FIFO and not yet
//            delivered (cleared on flush/reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic [$clog2(D):0] buf_level;
  logic [31:0]   word_count;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(D)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .bus        (bus),
    .buf_level  (buf_level),
    .word_count (word_count)
  );

  always #7 clk = ~clk;

  int tot = 0;
  int bad = 0;

  // FIFO contents, words owed to the consumer, and model bookkeeping
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] next_word = '0;
  logic [DW-1:0] rd_next = '0;
  logic          infl_m = 1'b0;
  int            wc_m = 0;
  logic          force_empty = 1'b0;

  // Pre-edge samples and expectations of the most recent cycle
  logic          s_rd_en, s_valid, hs;
  logic [DW-1:0] s_data, e_data;
  int            s_level, e_level;
  logic          e_rd_en, e_valid, e_infl;

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      next_word = next_word + 1'b1;
    end
  endtask

  // One clock: sample just before the edge, advance the model, present new
  // FIFO read data after the edge.
  task automatic cycle();
    logic [DW-1:0] w;
    bus.empty = force_empty || (fq.size() == 0);
    #1;
    s_rd_en = bus.rd_en;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    s_level = int'(buf_level);
    hs      = s_valid && bus.m_ready;
    e_rd_en = rstn && !flush && !bus.empty && (exp_q.size() < D);
    e_infl  = infl_m;
    e_level = exp_q.size() - (infl_m ? 1 : 0);
    e_valid = (e_level != 0);
    e_data  = (exp_q.size() != 0) ? exp_q[0] : '0;
    @(posedge clk);
    if (!rstn) begin
      exp_q.delete();
      infl_m = 1'b0;
      wc_m   = 0;
    end else if (flush) begin
      exp_q.delete();
      infl_m = 1'b0;
    end else begin
      if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (hs) wc_m++;
      infl_m = 1'b0;
      if (s_rd_en) begin
        w = (fq.size() != 0) ? fq.pop_front() : DW'($urandom);
        exp_q.push_back(w);
        rd_next = w;
        infl_m  = 1'b1;
      end
    end
    @(negedge clk);
    bus.rd_data = infl_m ? rd_next : DW'($urandom);
  endtask

  task automatic drain();
    int n;
    bus.m_ready = 1'b1;
    force_empty = 1'b0;
    flush = 1'b0;
    n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && n < 500) begin
      cycle();
      n++;
      if (hs) begin
        tot++;
        if (s_data !== e_data) begin
          bad++;
          $display("FAIL drain_data: got %0h expected %0h", s_data, e_data);
        end
      end
    end
    tot++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d words still owed", exp_q.size());
    end
  endtask

  task automatic test_reset();
    int got;
    rstn = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    push_words(5);
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      tot++;
      if (s_rd_en !== 1'b0 || s_valid !== 1'b0 || s_level != 0 ||
          s_data !== '0 || word_count !== 32'd0) begin
        bad++;
        $display("FAIL reset_state: rd_en=%b m_valid=%b level=%0d data=%0h wc=%0d required 0/0/0/0/0",
                 s_rd_en, s_valid, s_level, s_data, word_count);
      end
    end
    rstn = 1'b1;
    bus.m_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 30 && got < 5; k++) begin
      cycle();
      if (hs) begin
        tot++;
        if (s_data !== DW'(got)) begin
          bad++;
          $display("FAIL reset_order: got %0h required %0h", s_data, got);
        end
        got++;
      end
    end
    tot++;
    if (got != 5) begin
      bad++;
      $display("FAIL reset_count: delivered %0d required 5", got);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] base;
    int got;
    drain();
    base = next_word;
    push_words(100);
    bus.m_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 400 && got < 100; k++) begin
      cycle();
      if (hs) begin
        tot++;
        if (s_data !== DW'(base + DW'(got))) begin
          bad++;
          $display("FAIL stream_order: got %0h required %0h", s_data, DW'(base + DW'(got)));
        end
        got++;
      end
    end
    tot++;
    if (got != 100) begin
      bad++;
      $display("FAIL stream_count: delivered %0d required 100", got);
    end
    tot++;
`ifdef FIFO_READER_STATS_EN
    if (word_count !== 32'(wc_m)) begin
      bad++;
      $display("FAIL stream_word_count: got %0d required %0d", word_count, wc_m);
    end
`else
    if (word_count !== 32'd0) begin
      bad++;
      $display("FAIL stream_word_count: got %0d required 0", word_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] base;
    int reads;
    drain();
    base = next_word;
    push_words(20);
    bus.m_ready = 1'b0;
    reads = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (s_rd_en) reads++;
      if (s_valid) begin
        tot++;
        if (s_data !== base) begin
          bad++;
          $display("FAIL bp_data_stable: got %0h required %0h", s_data, base);
        end
      end
    end
    tot++;
    if (reads != D) begin
      bad++;
      $display("FAIL bp_reads: issued %0d required %0d", reads, D);
    end
    tot++;
    if (s_level != D) begin
      bad++;
      $display("FAIL bp_level: got %0d required %0d", s_level, D);
    end
    drain();
  endtask

  task automatic test_throughput();
    drain();
    push_words(60);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (k >= 2) begin
        tot++;
        if (hs !== 1'b1) begin
          bad++;
          $display("FAIL throughput_gap: cycle %0d handshake=%b required 1", k, hs);
        end
      end
    end
    drain();
  endtask

  task automatic test_flush();
    logic [DW-1:0] base;
    int k;
    drain();
    base = next_word;
    push_words(20);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    flush = 1'b1;
    cycle();
    tot++;
    if (s_level != 3 || e_infl !== 1'b1) begin
      bad++;
      $display("FAIL flush_setup: level=%0d inflight=%b required 3/1", s_level, e_infl);
    end
    flush = 1'b0;
    cycle();
    tot++;
    if (s_valid !== 1'b0 || s_level != 0) begin
      bad++;
      $display("FAIL flush_clear: m_valid=%b level=%0d required 0/0", s_valid, s_level);
    end
    bus.m_ready = 1'b1;
    k = 0;
    while (!hs && k < 20) begin
      cycle();
      k++;
    end
    tot++;
    if (!hs || s_data !== DW'(base + DW'(4))) begin
      bad++;
      $display("FAIL flush_next_word: got %0h valid=%b required %0h", s_data, hs, DW'(base + DW'(4)));
    end
    drain();
  endtask

  task automatic test_random();
    int got;
    int burst;
    int cyc;
    got = 0;
    burst = 0;
    cyc = 0;
    while (got < 10000 && cyc < 60000) begin
      if (fq.size() < 8) push_words(8);
      bus.m_ready = $urandom_range(0, 1) == 1;
      if (burst > 0) begin
        force_empty = 1'b1;
        burst--;
      end else if ($urandom_range(0, 9) == 0) begin
        force_empty = 1'b1;
        burst = $urandom_range(1, 8);
      end else begin
        force_empty = 1'b0;
      end
      cycle();
      cyc++;
      tot++;
      if (s_rd_en !== e_rd_en || s_valid !== e_valid || s_level != e_level) begin
        bad++;
        $display("FAIL rand_ctrl: rd_en=%b m_valid=%b level=%0d required %b/%b/%0d",
                 s_rd_en, s_valid, s_level, e_rd_en, e_valid, e_level);
      end
      tot++;
      if (e_infl && s_level >= D) begin
        bad++;
        $display("FAIL rand_full_capture: level=%0d with word in flight required <%0d", s_level, D);
      end
      if (hs) begin
        tot++;
        if (s_data !== e_data) begin
          bad++;
          $display("FAIL rand_data: got %0h required %0h", s_data, e_data);
        end
        got++;
      end
    end
    tot++;
    if (got < 10000) begin
      bad++;
      $display("FAIL rand_timeout: delivered %0d required 10000", got);
    end
    force_empty = 1'b0;
    drain();
    tot++;
`ifdef FIFO_READER_STATS_EN
    if (word_count !== 32'(wc_m)) begin
      bad++;
      $display("FAIL rand_word_count: got %0d required %0d", word_count, wc_m);
    end
`else
    if (word_count !== 32'd0) begin
      bad++;
      $display("FAIL rand_word_count: got %0d required 0", word_count);
    end
`endif
  endtask

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    bus.empty = 1'b1;
    bus.rd_data = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_throughput();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
`default_nettype wire
